// File: rtl/pipeline_stage_buffer_pkg.sv
// Shared types for the elastic pipeline stage buffer: state encoding and
// occupancy helper.
package pipeline_stage_buffer_pkg;

    localparam int unsigned STAGE_BUF_DEPTH_MAX = 2;
    localparam int unsigned OCC_WIDTH           = 2;

    // Encoding is {skid_valid, main_valid} so each valid is a direct state bit.
    typedef enum logic [1:0] {
        SB_EMPTY = 2'b00,
        SB_FULL1 = 2'b01,
        SB_FULL2 = 2'b11
    } stage_buf_state_e;

    function automatic logic [OCC_WIDTH-1:0] occ_of(input stage_buf_state_e s);
        logic [1:0] bits;
        bits = s;
        return OCC_WIDTH'(bits[0]) + OCC_WIDTH'(bits[1]);
    endfunction

endpackage

// File: rtl/pipeline_stage_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Elastic valid/ready pipeline register: depth 1 (plain register) or depth 2
// (main + skid entry with registered upstream ready), with flush and stall stats.
module pipeline_stage_buffer
    import pipeline_stage_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [DATA_WIDTH-1:0] inData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] outData,
    input  logic                  flush,
    output logic [OCC_WIDTH-1:0]  occupancy,
    output logic [CNT_WIDTH-1:0]  stallCycles,
    input  logic                  clrStats
);

    generate
        if ((DEPTH < 1) || (DEPTH > STAGE_BUF_DEPTH_MAX)) begin : g_bad_depth
            $error("pipeline_stage_buffer: DEPTH must be 1 or 2");
        end
        if ((DATA_WIDTH < 1) || (CNT_WIDTH < 1)) begin : g_bad_width
            $error("pipeline_stage_buffer: DATA_WIDTH and CNT_WIDTH must be >= 1");
        end
    endgenerate

    stage_buf_state_e      state;
    stage_buf_state_e      state_next;
    logic [DATA_WIDTH-1:0] main_data;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  load_main_in;
    logic                  load_main_skid;
    logic                  load_skid;
    logic                  accept;
    logic                  consume;
    logic [1:0]            state_bits;

    assign state_bits = state;
    assign outValid   = state_bits[0];
    assign outData    = main_data;
    assign occupancy  = occ_of(state);

    // Depth 1 forwards outReady so a full register can stream; depth 2 only
    // looks at the skid entry, keeping inReady a pure register output.
    assign inReady = (DEPTH == 1) ? (!state_bits[0] || outReady) : !state_bits[1];

    assign accept  = inValid && inReady;
    assign consume = outValid && outReady;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= SB_EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            state <= state_next;
            if (load_main_in) begin
                main_data <= inData;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= inData;
            end
        end
    end

    // Depth 1 never reaches FULL2: in FULL1 it only accepts alongside a consume.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            SB_EMPTY: begin
                if (accept) begin
                    state_next   = SB_FULL1;
                    load_main_in = 1'b1;
                end
            end
            SB_FULL1: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_next = SB_FULL2;
                    load_skid  = 1'b1;
                end else if (consume) begin
                    state_next = SB_EMPTY;
                end
            end
            SB_FULL2: begin
                if (consume) begin
                    state_next     = SB_FULL1;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = SB_EMPTY;
        endcase
        // Flushed beats are handshaken upstream but never stored.
        if (flush) begin
            state_next     = SB_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rstN),
        .inc  (outValid && !outReady),
        .clr  (clrStats),
        .count(stallCycles)
    );

endmodule
